// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: drives the data memory handshake, stalls upstream while an access is
// outstanding, forwards WB load data into stores, aborts stuck accesses and owns MEM/WB.
module mem_stage_ctrl #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_MemWrite,
   input  logic              ex_MemRead,
   input  logic [3:0]        ex_wb,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [DATA_W-1:0] ex_rt,
   input  logic [3:0]        ex_DstReg,
   input  logic [3:0]        ex_SrcReg1,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall,
   output logic              mem_err,
   output logic [3:0]        wb_ctrl,
   output logic [DATA_W-1:0] wb_alu,
   output logic [DATA_W-1:0] wb_mem,
   output logic [3:0]        wb_DstReg
);

   localparam int unsigned CntW = $clog2(TIMEOUT);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   logic                hold_we_q;
   logic [DATA_W-1:0]   hold_addr_q;
   logic [DATA_W-1:0]   hold_wdata_q;
   logic [3:0]          hold_wb_q;
   logic [3:0]          hold_dst_q;
   logic [3:0]          wb_ctrl_q;
   logic [DATA_W-1:0]   wb_alu_q;
   logic [DATA_W-1:0]   wb_mem_q;
   logic [3:0]          wb_dst_q;
   logic                err_q;

   logic                acc;
   logic                fwd;
   logic [DATA_W-1:0]   sdata;
   logic                in_idle;
   logic                in_wait;
   logic                abort;

   // Store data comes from the load sitting in MEM/WB when it targets the store's source reg.
   always_comb begin
      acc     = ex_MemRead | ex_MemWrite;
      fwd     = ex_MemWrite & wb_ctrl_q[3] & wb_ctrl_q[2] &
                (wb_dst_q == ex_SrcReg1) & (ex_SrcReg1 != 4'd0);
      sdata   = fwd ? wb_mem_q : ex_rt;
      in_idle = (state_q == StIdle);
      in_wait = (state_q == StWait);
      abort   = in_wait & ~mem_ready & (cnt_q == CntMax);
   end

   // Outputs are gated by reset so an asserted reset drops the request immediately.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      stall     = 1'b0;
      if (rst) begin
         if (in_idle) begin
            mem_req   = acc;
            mem_we    = ex_MemWrite;
            mem_addr  = ex_result;
            mem_wdata = sdata;
         end else begin
            mem_req   = 1'b1;
            mem_we    = hold_we_q;
            mem_addr  = hold_addr_q;
            mem_wdata = hold_wdata_q;
         end
         stall = (in_idle & acc & ~mem_ready) | (in_wait & ~mem_ready & ~abort);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         hold_we_q    <= 1'b0;
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
         hold_wb_q    <= 4'd0;
         hold_dst_q   <= 4'd0;
         wb_ctrl_q    <= 4'd0;
         wb_alu_q     <= '0;
         wb_mem_q     <= '0;
         wb_dst_q     <= 4'd0;
         err_q        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (acc && !mem_ready) begin
                  hold_we_q    <= ex_MemWrite;
                  hold_addr_q  <= ex_result;
                  hold_wdata_q <= sdata;
                  hold_wb_q    <= ex_wb;
                  hold_dst_q   <= ex_DstReg;
                  cnt_q        <= '0;
                  state_q      <= StWait;
                  wb_ctrl_q    <= 4'd0;
                  wb_alu_q     <= '0;
                  wb_mem_q     <= '0;
                  wb_dst_q     <= 4'd0;
               end else begin
                  wb_ctrl_q <= ex_wb;
                  wb_alu_q  <= ex_result;
                  wb_dst_q  <= ex_DstReg;
                  wb_mem_q  <= (acc && !ex_MemWrite) ? mem_rdata : '0;
               end
            end
            StWait: begin
               if (mem_ready || abort) begin
                  wb_ctrl_q <= hold_wb_q;
                  wb_alu_q  <= hold_addr_q;
                  wb_dst_q  <= hold_dst_q;
                  wb_mem_q  <= (mem_ready && !hold_we_q) ? mem_rdata : '0;
                  state_q   <= StIdle;
                  if (!mem_ready) begin
                     err_q <= 1'b1;
                  end
               end else begin
                  cnt_q     <= cnt_q + 1'b1;
                  wb_ctrl_q <= 4'd0;
                  wb_alu_q  <= '0;
                  wb_mem_q  <= '0;
                  wb_dst_q  <= 4'd0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mem_err   = err_q;
   assign wb_ctrl   = wb_ctrl_q;
   assign wb_alu    = wb_alu_q;
   assign wb_mem    = wb_mem_q;
   assign wb_DstReg = wb_dst_q;

endmodule
